// File: rtl/tea_job_ctrl_pkg.sv
// tea_job_ctrl_pkg: shared state encoding, IO map and byte-lane helper for the TEA job controller.
package tea_job_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    localparam logic [4:0] TEA_IO_DATA0 = 5'h00;
    localparam logic [4:0] TEA_IO_DATA7 = 5'h07;
    localparam logic [4:0] TEA_IO_CTRL  = 5'h1F;
    localparam int         CTRL_REQ_N   = 0;
    localparam int         CTRL_RES     = 1;

    // IO byte k sits at job_data[63-8k -: 8], i.e. LSB index 8*(7-k).
    function automatic logic [5:0] byte_lsb(input logic [2:0] k);
        return {~k, 3'b000};
    endfunction

endpackage

// File: rtl/tea_wdt.sv
// tea_wdt: saturating watchdog counter with clear/enable and limit compare; limit 0 disables expiry.
module tea_wdt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // Equality, not >=: lowering the limit below the count mid-job never fires.
    assign expired = (limit != '0) && (cnt_q == limit - 1'b1);

endmodule

// File: rtl/tea_job_ctrl.sv
// tea_job_ctrl: host job intake, tea_cpu IO mailbox and result return with watchdog abort.
module tea_job_ctrl
    import tea_job_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 16,
    parameter int IO_AW     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [63:0]          job_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [63:0]          res_data,
    output logic                 res_timeout,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic                 busy,
    input  logic [IO_AW-1:0]     io_addr,
    input  logic                 io_rd,
    input  logic                 io_wr,
    input  logic [7:0]           io_wrdata,
    output logic [7:0]           io_rddata
);

    state_t      state_q, state_d;
    logic [63:0] in_buf_q, in_buf_d, out_buf_q, out_buf_d;
    logic        res_timeout_q, res_timeout_d;
    logic        is_data, is_ctrl, accept, done, wdt_expired, io_rd_unused;

    assign io_rd_unused = io_rd;
    assign is_data      = io_addr <= IO_AW'(TEA_IO_DATA7);
    assign is_ctrl      = io_addr == IO_AW'(TEA_IO_CTRL);
    assign accept       = state_q == ST_IDLE && job_valid;
    assign done         = state_q == ST_RUN && io_wr && is_ctrl && io_wrdata[CTRL_REQ_N];

    tea_wdt #(.W(TIMEOUT_W)) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (state_q == ST_RUN),
        .limit   (timeout_cycles),
        .expired (wdt_expired)
    );

    always_comb begin
        state_d       = state_q;
        in_buf_d      = in_buf_q;
        out_buf_d     = out_buf_q;
        res_timeout_d = res_timeout_q;
        if (accept) begin
            state_d       = ST_RUN;
            in_buf_d      = job_data;
            out_buf_d     = '0;
            res_timeout_d = 1'b0;
        end
        if (state_q == ST_RUN) begin
            if (io_wr && is_data) out_buf_d[byte_lsb(io_addr[2:0]) +: 8] = io_wrdata;
            if (done || wdt_expired) begin
                state_d       = ST_RESULT;
                res_timeout_d = !done;
            end
        end
        if (state_q == ST_RESULT && res_ready) begin
            state_d       = ST_IDLE;
            res_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            in_buf_q      <= '0;
            out_buf_q     <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_buf_q      <= in_buf_d;
            out_buf_q     <= out_buf_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    always_comb begin
        io_rddata = 8'h00;
        io_rddata[CTRL_REQ_N] = is_ctrl && state_q != ST_RUN;
        io_rddata[CTRL_RES]   = is_ctrl && state_q == ST_RESULT;
        io_rddata = is_data ? in_buf_q[byte_lsb(io_addr[2:0]) +: 8] : io_rddata;
    end

    assign job_ready   = state_q == ST_IDLE;
    assign res_valid   = state_q == ST_RESULT;
    assign busy        = state_q != ST_IDLE;
    assign res_data    = out_buf_q;
    assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_tea_job_ctrl.sv
// tb_tea_job_ctrl: directed plan plus random soak against a byte-array mailbox model.
module tb_tea_job_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jv, rr, rd, wr;
    logic [63:0] jd;
    logic [15:0] tc;
    logic [4:0]  addr;
    logic [7:0]  wd;
    logic        job_ready, res_valid, res_timeout, busy;
    logic [63:0] res_data;
    logic [7:0]  io_rddata;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase 0 = waiting for job, 1 = firmware working, 2 = result offered.
    int         m_ph;
    int         m_el;
    bit         m_to;
    logic [7:0] m_in [8];
    logic [7:0] m_out[8];

    tea_job_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .job_valid      (jv),
        .job_ready      (job_ready),
        .job_data       (jd),
        .res_valid      (res_valid),
        .res_ready      (rr),
        .res_data       (res_data),
        .res_timeout    (res_timeout),
        .timeout_cycles (tc),
        .busy           (busy),
        .io_addr        (addr),
        .io_rd          (rd),
        .io_wr          (wr),
        .io_wrdata      (wd),
        .io_rddata      (io_rddata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_res();
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[63-8*k -: 8] = m_out[k];
        return r;
    endfunction

    function automatic logic [7:0] model_rd(input logic [4:0] a);
        if (a < 8)  return m_in[a];
        if (a == 31) return {6'b0, m_ph == 2, m_ph != 1};
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_el = 0; m_to = 0;
        for (int k = 0; k < 8; k++) begin m_in[k] = 8'h00; m_out[k] = 8'h00; end
    endtask

    task automatic compare_all();
        check("ready", job_ready, m_ph == 0);
        check("valid", res_valid, m_ph == 2);
        check("busy", busy, m_ph != 0);
        check("tmo", res_timeout, m_to);
        check("rd", io_rddata, model_rd(addr));
        if (m_ph == 2) check("data", res_data, model_res());
    endtask

    task automatic tick();
        bit done, expd;
        done = m_ph == 1 && wr && addr == 31 && wd[0];
        expd = m_ph == 1 && tc != 0 && m_el == int'(tc) - 1;
        if (m_ph == 0) begin
            if (jv) begin
                for (int k = 0; k < 8; k++) begin m_in[k] = jd[63-8*k -: 8]; m_out[k] = 8'h00; end
                m_el = 0; m_to = 0; m_ph = 1;
            end
        end else if (m_ph == 1) begin
            if (wr && addr < 8) m_out[addr] = wd;
            if (m_el < 65535) m_el++;
            if (done) begin m_ph = 2; m_to = 0; end
            else if (expd) begin m_ph = 2; m_to = 1; end
        end else if (rr) begin
            m_ph = 0; m_to = 0;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic quiet();
        jv = 0; rr = 0; wr = 0; wd = 8'h00; rd = 0;
    endtask

    task automatic accept_job(input logic [63:0] d);
        jd = d; jv = 1; tick(); jv = 0;
    endtask

    task automatic io_write(input logic [4:0] a, input logic [7:0] v);
        addr = a; wd = v; wr = 1; tick(); wr = 0;
    endtask

    task automatic release_result();
        rr = 1; tick(); rr = 0;
    endtask

    initial begin
        int n;
        quiet(); jd = '0; tc = 16'd0; addr = 5'h1F;
        reset_dut();
        tick();
        check("rst_ctrl", io_rddata, 8'h01);

        accept_job(64'h12345678_11223344);
        addr = 5'd0;  tick(); check("rd0", io_rddata, 8'h12);
        addr = 5'd3;  tick(); check("rd3", io_rddata, 8'h78);
        addr = 5'd7;  tick(); check("rd7", io_rddata, 8'h44);
        addr = 5'h1F; tick(); check("rd_ctrl_run", io_rddata, 8'h00);

        for (int k = 0; k < 8; k++) io_write(5'(k), 8'hA0 + 8'(k));
        io_write(5'h1F, 8'h01);
        check("done_valid", res_valid, 1'b1);
        check("done_data", res_data, 64'hA0A1A2A3_A4A5A6A7);
        check("done_tmo", res_timeout, 1'b0);
        check("done_ctrl", io_rddata, 8'h03);
        repeat (5) begin tick(); check("hold_data", res_data, 64'hA0A1A2A3_A4A5A6A7); end
        release_result();
        check("release_ready", job_ready, 1'b1);

        accept_job({$urandom, $urandom});
        repeat (3) tick();
        addr = 5'h1F;
        reset_dut();
        tick();
        check("midrst_ready", job_ready, 1'b1);
        check("midrst_valid", res_valid, 1'b0);
        check("midrst_ctrl", io_rddata, 8'h01);

        tc = 16'd20;
        accept_job({$urandom, $urandom});
        n = 0;
        while (!res_valid && n < 40) begin tick(); n++; end
        check("tmo_latency", n, 20);
        check("tmo_flag", res_timeout, 1'b1);
        check("tmo_data", res_data, 64'h0);
        release_result();

        tc = 16'd0;
        accept_job({$urandom, $urandom});
        repeat (1000) tick();
        check("wdt_off_valid", res_valid, 1'b0);
        io_write(5'h1F, 8'h01);
        release_result();

        tc = 16'd8;
        accept_job({$urandom, $urandom});
        repeat (6) tick();
        io_write(5'd5, 8'h5A);
        io_write(5'h1F, 8'h01);
        check("tie_tmo", res_timeout, 1'b0);
        check("tie_byte5", res_data[23:16], 8'h5A);
        release_result();

        tc = 16'd0;
        io_write(5'd3, 8'hFF);
        io_write(5'h1F, 8'h01);
        check("idle_done_ready", job_ready, 1'b1);
        accept_job({$urandom, $urandom});
        io_write(5'h1F, 8'h00);
        check("ctrl0_busy", busy, 1'b1);
        check("ctrl0_valid", res_valid, 1'b0);
        io_write(5'h1F, 8'h01);
        io_write(5'd3, 8'h77);
        check("result_wr_data", res_data, 64'h0);
        addr = 5'h10; tick();
        check("rd_unmapped", io_rddata, 8'h00);
        release_result();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) reset_dut();
            if ($urandom_range(0, 49) == 0) tc = 16'($urandom_range(0, 40));
            jv = 1'($urandom_range(0, 1));
            jd = {$urandom, $urandom};
            rr = $urandom_range(0, 3) == 0;
            rd = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 3);
            addr = n < 2 ? 5'($urandom_range(0, 7)) : n == 2 ? 5'h1F : 5'($urandom_range(8, 30));
            wr = $urandom_range(0, 9) < 3;
            wd = 8'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
